// File: rtl/ila_pkg.sv
// Shared capture-state encoding and default widths for the capture buffer writer.
package ila_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_TS_WIDTH   = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } capture_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read (old data on collision).
module capture_ram
   import ila_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int MEMORY_SIZE = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [MEMORY_SIZE];

   // Storage is deliberately left out of reset so it maps onto RAM primitives.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rdata <= '0;
      else        rdata <= mem[raddr];
   end

endmodule

// File: rtl/capture_write_ctrl.sv
// Trigger-aware capture-buffer writer: circular RAM plus arm/trigger/post-trigger FSM.
// Optional trigger timestamp output enabled by defining ILA_TRIG_TIMESTAMP_EN.
//
// state    | meaning
// ST_IDLE  | waiting for arm, no RAM writes
// ST_ARMED | writing pre-trigger history, watching for a qualified trigger
// ST_POST  | writing post-trigger samples until the counter runs out
// ST_DONE  | capture frozen, read port only
module capture_write_ctrl
   import ila_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef ILA_TRIG_TIMESTAMP_EN
   , parameter int TS_WIDTH = DEF_TS_WIDTH
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic [ADDR_WIDTH-1:0] post_count,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  trigger,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  primed,
   output logic                  triggered,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic [ADDR_WIDTH-1:0] start_addr
`ifdef ILA_TRIG_TIMESTAMP_EN
   , output logic [TS_WIDTH-1:0] trig_time
`endif
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   capture_state_t        state, state_nxt;
   logic [ADDR_WIDTH-1:0] waddr_nxt, trig_addr_nxt, post_cnt, post_cnt_nxt;
   logic                  primed_nxt, triggered_nxt, wr_en;
`ifdef ILA_TRIG_TIMESTAMP_EN
   logic [TS_WIDTH-1:0]   sample_cnt, sample_cnt_nxt, trig_time_nxt;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         waddr     <= '0;
         primed    <= 1'b0;
         triggered <= 1'b0;
         trig_addr <= '0;
         post_cnt  <= '0;
`ifdef ILA_TRIG_TIMESTAMP_EN
         sample_cnt <= '0;
         trig_time  <= '0;
`endif
      end else begin
         state     <= state_nxt;
         waddr     <= waddr_nxt;
         primed    <= primed_nxt;
         triggered <= triggered_nxt;
         trig_addr <= trig_addr_nxt;
         post_cnt  <= post_cnt_nxt;
`ifdef ILA_TRIG_TIMESTAMP_EN
         sample_cnt <= sample_cnt_nxt;
         trig_time  <= trig_time_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      waddr_nxt     = waddr;
      primed_nxt    = primed;
      triggered_nxt = triggered;
      trig_addr_nxt = trig_addr;
      post_cnt_nxt  = post_cnt;
      wr_en         = 1'b0;
`ifdef ILA_TRIG_TIMESTAMP_EN
      sample_cnt_nxt = sample_cnt;
      trig_time_nxt  = trig_time;
`endif
      // arm wins over everything, and the sample in the arm cycle is dropped
      if (arm) begin
         state_nxt     = ST_ARMED;
         waddr_nxt     = '0;
         primed_nxt    = 1'b0;
         triggered_nxt = 1'b0;
         trig_addr_nxt = '0;
         post_cnt_nxt  = post_count;
`ifdef ILA_TRIG_TIMESTAMP_EN
         sample_cnt_nxt = '0;
         trig_time_nxt  = '0;
`endif
      end else if (write_enable && (state == ST_ARMED || state == ST_POST)) begin
         wr_en     = 1'b1;
         waddr_nxt = waddr + ADDR_WIDTH'(1);
         if (waddr == ADDR_LAST) primed_nxt = 1'b1;
`ifdef ILA_TRIG_TIMESTAMP_EN
         sample_cnt_nxt = sample_cnt + TS_WIDTH'(1);
`endif
         if (state == ST_ARMED) begin
            if (trigger) begin
               trig_addr_nxt = waddr;
               triggered_nxt = 1'b1;
`ifdef ILA_TRIG_TIMESTAMP_EN
               trig_time_nxt = sample_cnt;
`endif
               state_nxt = (post_cnt == '0) ? ST_DONE : ST_POST;
            end
         end else begin
            post_cnt_nxt = post_cnt - ADDR_WIDTH'(1);
            if (post_cnt == ADDR_WIDTH'(1)) state_nxt = ST_DONE;
         end
      end
   end

   assign done       = (state == ST_DONE);
   assign start_addr = primed ? waddr : '0;

   capture_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (waddr),
      .wdata (data),
      .raddr (raddr),
      .rdata (rdata)
   );

endmodule
